// File: rtl/cpu_bus_ctrl_pkg.sv
// Shared address map, status bit positions and commit FSM states for the
// CPU bus decoder / peripheral register block.
package cpu_bus_ctrl_pkg;

  localparam logic [31:0] DIP_ADDR    = 32'h8000_0000;
  localparam logic [31:0] LED_ADDR    = 32'h8000_0004;
  localparam logic [31:0] BTN_ADDR    = 32'h8000_0008;
  localparam logic [31:0] STATUS_ADDR = 32'h8000_000C;
  localparam logic [31:0] EDGE_ADDR   = 32'h8000_0010;
  localparam logic [31:0] CYCLE_ADDR  = 32'h8000_0014;
  localparam logic [31:0] AUDIO_BASE  = 32'h8000_0100;

  localparam int unsigned ST_FULL      = 0;
  localparam int unsigned ST_INIT_DONE = 1;
  localparam int unsigned ST_BUS_ERR   = 2;
  localparam int unsigned ST_OVERFLOW  = 3;

  typedef enum logic {
    IDLE,
    STALL
  } commit_state_e;

  function automatic logic word_hit(input logic [31:0] a, input logic [31:0] reg_addr);
    return a[31:2] == reg_addr[31:2];
  endfunction

endpackage

// File: rtl/cpu_bus_ctrl_if.sv
// CPU valid/ready memory bus: the CPU is the master, the decoder the slave.
interface cpu_bus_ctrl_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        valid;
  logic [31:0] rdata;
  logic        ready;

  modport master (output addr, wdata, wstrb, valid, input rdata, ready);
  modport slave  (input addr, wdata, wstrb, valid, output rdata, ready);
endinterface

// File: rtl/cpu_bus_ctrl_btn_edge_latch.sv
// Button synchroniser with rising-edge detect and a W1C sticky latch per bit.
module btn_edge_latch #(
  parameter int unsigned BTN_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BTN_W-1:0] buttons,
  input  logic [BTN_W-1:0] clr,
  output logic [BTN_W-1:0] sync,
  output logic [BTN_W-1:0] latch
);

  logic [BTN_W-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d, latch_q, latch_d;

  always_comb begin
    s1_d    = buttons;
    s2_d    = s1_q;
    s3_d    = s2_q;
    // a new edge overrides a clear landing on the same edge
    latch_d = (latch_q & ~clr) | (s2_q & ~s3_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      latch_q <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      latch_q <= latch_d;
    end
  end

  assign sync  = s2_q;
  assign latch = latch_q;

endmodule

// File: rtl/cpu_bus_ctrl.sv
// CPU bus decoder: RAM window passthrough, debug I/O registers, cycle counter,
// sticky flags and the multi-channel audio staging/commit path to the ADAU FIFO.
module cpu_bus_ctrl
  import cpu_bus_ctrl_pkg::*;
#(
  parameter logic [31:0] RAM_BASE      = 32'h0001_0000,
  parameter int unsigned RAM_AW        = 15,
  parameter int unsigned DIP_W         = 8,
  parameter int unsigned LED_W         = 8,
  parameter int unsigned BTN_W         = 5,
  parameter int unsigned AUDIO_CH      = 2,
  parameter int unsigned SAMPLE_W      = 24,
  parameter bit          STALL_ON_FULL = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  cpu_bus_ctrl_if.slave                bus,
  input  logic [DIP_W-1:0]             dip,
  input  logic [BTN_W-1:0]             buttons,
  output logic [LED_W-1:0]             led,
  output logic [RAM_AW-1:0]            ram_addr,
  output logic [31:0]                  ram_wdata,
  output logic [3:0]                   ram_wstrb,
  output logic                         ram_valid,
  input  logic [31:0]                  ram_rdata,
  input  logic                         ram_ready,
  output logic [AUDIO_CH*SAMPLE_W-1:0] adau_audio,
  output logic                         adau_audio_valid,
  input  logic                         adau_audio_full,
  input  logic                         adau_init_done
);

  logic in_ram, hit_dip, hit_led, hit_btn, hit_status, hit_edge, hit_cycle;
  logic in_audio, mapped, is_wr, commit, ready, push, stall;
  logic [5:0]          ch;
  logic [31:0]         byte_mask, rdata;
  logic [SAMPLE_W-1:0] smp, smask;
  logic [BTN_W-1:0]    btn_sync, btn_latch, btn_clr;

  commit_state_e    state_q, state_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d, ovf_q, ovf_d;

  assign in_ram     = bus.addr[31:RAM_AW] == RAM_BASE[31:RAM_AW];
  assign hit_dip    = word_hit(bus.addr, DIP_ADDR);
  assign hit_led    = word_hit(bus.addr, LED_ADDR);
  assign hit_btn    = word_hit(bus.addr, BTN_ADDR);
  assign hit_status = word_hit(bus.addr, STATUS_ADDR);
  assign hit_edge   = word_hit(bus.addr, EDGE_ADDR);
  assign hit_cycle  = word_hit(bus.addr, CYCLE_ADDR);
  assign ch         = bus.addr[7:2];
  assign in_audio   = (bus.addr[31:8] == AUDIO_BASE[31:8]) && (ch < 6'(AUDIO_CH));
  assign mapped     = in_ram | hit_dip | hit_led | hit_btn | hit_status | hit_edge
                    | hit_cycle | in_audio;
  assign is_wr      = |bus.wstrb;
  assign commit     = bus.valid && in_audio && is_wr && (ch == 6'(AUDIO_CH - 1));

  // samples are MSB-aligned, so strobes apply to the top SAMPLE_W bits only
  assign byte_mask = {{8{bus.wstrb[3]}}, {8{bus.wstrb[2]}}, {8{bus.wstrb[1]}}, {8{bus.wstrb[0]}}};
  assign smp       = bus.wdata[31 -: SAMPLE_W];
  assign smask     = byte_mask[31 -: SAMPLE_W];

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit) begin
          if (!adau_audio_full) begin
            push = 1'b1;
          end else if (STALL_ON_FULL) begin
            stall   = 1'b1;
            state_d = STALL;
          end
        end
      end
      STALL: begin
        if (!commit) begin
          state_d = IDLE;
        end else if (adau_audio_full) begin
          stall = 1'b1;
        end else begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  assign ready = bus.valid && (in_ram ? ram_ready : !stall);

  always_comb begin
    led_d     = led_q;
    cnt_d     = cnt_q + 32'd1;
    bus_err_d = bus_err_q;
    ovf_d     = ovf_q;
    if (ready && hit_led && bus.wstrb[0]) led_d = bus.wdata[LED_W-1:0];
    if (ready && hit_status && is_wr) begin
      if (bus.wdata[ST_BUS_ERR])  bus_err_d = 1'b0;
      if (bus.wdata[ST_OVERFLOW]) ovf_d     = 1'b0;
    end
    if (bus.valid && !mapped) bus_err_d = 1'b1;
    if (commit && adau_audio_full && !STALL_ON_FULL) ovf_d = 1'b1;
  end

  always_comb begin
    rdata = '0;
    if (in_ram)          rdata = ram_rdata;
    else if (hit_dip)    rdata = 32'(dip);
    else if (hit_led)    rdata = 32'(led_q);
    else if (hit_btn)    rdata = 32'(btn_sync);
    else if (hit_status) begin
      rdata[ST_FULL]      = adau_audio_full;
      rdata[ST_INIT_DONE] = adau_init_done;
      rdata[ST_BUS_ERR]   = bus_err_q;
      rdata[ST_OVERFLOW]  = ovf_q;
    end
    else if (hit_edge)   rdata = 32'(btn_latch);
    else if (hit_cycle)  rdata = cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      led_q     <= '0;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      led_q     <= led_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
      ovf_q     <= ovf_d;
    end
  end

  // the last channel never stages: its write is the commit and uses live wdata
  for (genvar g = 0; g < AUDIO_CH - 1; g++) begin : g_stage
    logic [SAMPLE_W-1:0] stg_q, stg_d;

    always_comb begin
      stg_d = stg_q;
      if (ready && in_audio && is_wr && (ch == 6'(g))) stg_d = (stg_q & ~smask) | (smp & smask);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) stg_q <= '0;
      else       stg_q <= stg_d;
    end

    assign adau_audio[(AUDIO_CH-g)*SAMPLE_W-1 -: SAMPLE_W] = stg_q;
  end
  assign adau_audio[SAMPLE_W-1:0] = smp;

  assign btn_clr = (ready && hit_edge && is_wr) ? bus.wdata[BTN_W-1:0] : '0;

  btn_edge_latch #(.BTN_W(BTN_W)) u_btn (
    .clk     (clk),
    .reset   (reset),
    .buttons (buttons),
    .clr     (btn_clr),
    .sync    (btn_sync),
    .latch   (btn_latch)
  );

  assign bus.rdata        = rdata;
  assign bus.ready        = ready;
  assign led              = led_q;
  assign ram_addr         = bus.addr[RAM_AW-1:0];
  assign ram_wdata        = bus.wdata;
  assign ram_wstrb        = bus.wstrb;
  assign ram_valid        = bus.valid && in_ram;
  assign adau_audio_valid = push;

endmodule

// File: doc/cpu_bus_ctrl.md
Name: cpu_bus_ctrl

Overview:
Parametrised CPU bus decoder and peripheral register block sitting between the soft CPU's valid/ready memory bus and the RAM, debug I/O and ADAU audio FIFO. It generalises the RAM window, GPIO widths, audio channel count and sample width. New features over the fixed-map decoder:
- selectable stall-on-full audio back-pressure
- synchronised button edge latching
- a free-running cycle counter
- sticky bus-error and audio-overflow flags

Parameters:
RAM_BASE, 32'h0001_0000, RAM window base; must be aligned to 2**RAM_AW
RAM_AW, 15, RAM byte-address width; window size 2**RAM_AW bytes
DIP_W, 8, DIP switch width (1..32)
LED_W, 8, LED width (1..8)
BTN_W, 5, button width (1..32)
AUDIO_CH, 2, audio channels (1..8)
SAMPLE_W, 24, sample width (1..32); taken MSB-aligned from wdata[31:32-SAMPLE_W]
STALL_ON_FULL, 1, 1: hold ready low while FIFO full; 0: drop sample and set overflow

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
addr  in  32  CPU byte address
wdata  in  32  CPU write data
wstrb  in  4  byte strobes; 0 means read
valid  in  1  CPU request; held until ready
rdata  out  32  read data, valid when ready=1
ready  out  1  transfer complete
dip  in  DIP_W  DIP switches
buttons  in  BTN_W  raw asynchronous buttons
led  out  LED_W  LED register
ram_addr  out  RAM_AW  addr[RAM_AW-1:0]
ram_wdata  out  32  wdata passthrough
ram_wstrb  out  4  wstrb passthrough
ram_valid  out  1  valid and address in RAM window
ram_rdata  in  32  RAM read data
ram_ready  in  1  RAM ready
adau_audio  out  AUDIO_CH*SAMPLE_W  frame; channel 0 in the MSBs
adau_audio_valid  out  1  FIFO push strobe
adau_audio_full  in  1  FIFO full
adau_init_done  in  1  ADAU configuration done

Behaviour:
Memory map (word addresses, exact match except RAM):
- RAM window: rdata=ram_rdata, ready=ram_ready.
- 0x8000_0000 DIP (RO).
- 0x8000_0004 LED (RW); wstrb[0] writes wdata[LED_W-1:0].
- 0x8000_0008 synchronised buttons (RO).
- 0x8000_000C status:
  - bit0 full (RO), bit1 init_done (RO)
  - bit2 bus_err (W1C), bit3 overflow (W1C); any nonzero wstrb qualifies
- 0x8000_0010 button edge latch (W1C per bit).
- 0x8000_0014 cycle counter (RO, 32-bit, wraps 0xFFFF_FFFF to 0).
- 0x8000_0100+4*i audio channel i, i<AUDIO_CH:
  - write-only, reads 0
  - byte-strobed write into staging register i; bytes below SAMPLE_W are ignored

Handshake and timing:
- All non-RAM accesses complete combinationally (ready=1 in the cycle valid is seen), except a stalled commit.
- Register writes take effect on the clk edge where valid&&ready.
- Unmapped access with valid: ready=1, rdata=0, bus_err set on that edge. Writes to RO registers are ignored and do not set bus_err.
- Unmapped read data is 0; RO bits of readable registers are 0-extended.

Commit (write with wstrb!=0 to channel AUDIO_CH-1):
- adau_audio = {staging[0..AUDIO_CH-2], live wdata sample}.
- Not full: adau_audio_valid=1 and ready=1 in that single cycle.
- Full, STALL_ON_FULL=1: ready=0 and adau_audio_valid=0 until full deasserts; then push in that cycle. Stall states are IDLE and STALL; STALL returns to IDLE on the push.
- Full, STALL_ON_FULL=0: ready=1, no push, overflow set.
- AUDIO_CH=1: every channel-0 write commits directly.
- adau_audio_valid is never asserted without valid.

Buttons:
- 2-flop synchroniser, then rising-edge detect sets the latch bit.
- Set and W1C clear in the same cycle: set wins.

Sticky flags: set and clear in the same cycle, set wins.

Reset (asynchronous, any time including mid-stall): led=0, staging=0, latch=0, sync flops=0, counter=0, flags=0, FSM=IDLE. Combinational outputs follow inputs.

Decomposition:
- Shared package: address map constants (offsets, AUDIO_BASE 0x8000_0100), status bit indices.
- One natural sub-module: btn_edge_latch (synchroniser + edge detect + W1C latch, parametrised BTN_W).

Test Plan:
- Reset, read 0x8000_000C with full=0, init_done=1 -> rdata=0x2; read 0x8000_0014 twice 5 cycles apart -> difference 5.
- Write 0x8000_0100=0x123456_00, then 0x8000_0104=0xABCDEF_00 with full=0 -> one-cycle adau_audio_valid, adau_audio=0x123456ABCDEF, ready=1 same cycle.
- STALL_ON_FULL=1, full=1 for 4 cycles during commit -> ready=0 and no push for 4 cycles, single push in cycle 5; STALL_ON_FULL=0 same stimulus -> no push, status bit3=1, cleared by writing 0x8 to 0x8000_000C.
- Pulse buttons[2] high 3 cycles -> read 0x8000_0010 = 0x4 after ≥2 sync cycles; write 0x4 in the same cycle as a new edge -> bit stays 1.
- Read 0x9000_0000 -> ready=1, rdata=0, status bit2=1; RAM address 0x0001_7FFC -> ram_valid=1, ram_addr=0x7FFC, ready follows ram_ready.
- Assert reset mid-stall -> ready/FSM return to IDLE, led=0, counter=0 immediately (asynchronous).
